// File: rtl/bs_job_dispatcher.sv
// bs_job_dispatcher
//   Dispatches option-pricing jobs from the data controller onto NUM_ENG
//   Black-Scholes engines, round-robin, and collects their results back onto a
//   single result port, also round-robin. Tracks per-engine occupancy and
//   reports run completion, run length and job counts.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   start                   run start pulse (honoured in IDLE / DONE)
//   job_avail, out_of_data  job source status from the data controller
//   job_pop, eng_load       job consumed / one-hot engine that latches it
//   eng_start               per-engine start level (engine LOADED)
//   eng_ready, eng_done     per-engine accept / result-valid pulse
//   eng_idle                per-engine idle indication
//   res_valid, res_sel      result presented and the engine that owns it
//   res_ready               data controller takes the presented result
//   busy, done              run in progress / run complete
//   proto_err               sticky: unexpected eng_done seen
//   cycles                  saturating run length in clocks
//   jobs_issued/retired     per-run job counts (wrap modulo 2^CNT_W)
module bs_job_dispatcher #(
  parameter int  NUM_ENG = 4,
  parameter int  CNT_W   = 16,
  localparam int SEL_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               job_avail,
  input  logic               out_of_data,
  output logic               job_pop,
  output logic [NUM_ENG-1:0] eng_load,
  output logic [NUM_ENG-1:0] eng_start,
  input  logic [NUM_ENG-1:0] eng_ready,
  input  logic [NUM_ENG-1:0] eng_done,
  input  logic [NUM_ENG-1:0] eng_idle,
  output logic               res_valid,
  output logic [SEL_W-1:0]   res_sel,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic               proto_err,
  output logic [31:0]        cycles,
  output logic [CNT_W-1:0]   jobs_issued,
  output logic [CNT_W-1:0]   jobs_retired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {E_FREE, E_LOADED, E_RUNNING, E_HOLD} eng_st_e;

  state_e             state_q, state_d;
  eng_st_e            eng_st_q [NUM_ENG];
  eng_st_e            eng_st_d [NUM_ENG];
  logic [SEL_W-1:0]   dp_q, dp_d;
  logic [SEL_W-1:0]   cp_q, cp_d;
  logic               res_valid_q, res_valid_d;
  logic [SEL_W-1:0]   res_sel_q, res_sel_d;
  logic               proto_err_q, proto_err_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [CNT_W-1:0]   jobs_issued_q, jobs_issued_d;
  logic [CNT_W-1:0]   jobs_retired_q, jobs_retired_d;

  logic [NUM_ENG-1:0] free_mask, hold_mask, loaded_mask, hold_d;
  logic [SEL_W-1:0]   disp_sel;
  logic               clear, collect;

  // First set bit of mask at or after ptr, wrapping modulo NUM_ENG.
  // Scanning from the far end lets the nearest candidate win last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_ENG-1:0] mask,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_ENG);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] sel);
    return SEL_W'((int'(sel) + 1) % NUM_ENG);
  endfunction

  always_comb begin
    free_mask   = '0;
    hold_mask   = '0;
    loaded_mask = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      free_mask[i]   = (eng_st_q[i] == E_FREE);
      hold_mask[i]   = (eng_st_q[i] == E_HOLD);
      loaded_mask[i] = (eng_st_q[i] == E_LOADED);
    end

    clear = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (out_of_data && !job_avail) state_d = S_DRAIN;
      S_DRAIN: if ((&free_mask) && (&eng_idle)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    disp_sel = rr_pick(free_mask, dp_q);
    job_pop  = (state_q == S_RUN) && job_avail && (|free_mask);
    eng_load = '0;
    if (job_pop) eng_load[disp_sel] = 1'b1;

    collect = res_valid_q && res_ready;

    hold_d = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      eng_st_d[i] = eng_st_q[i];
      case (eng_st_q[i])
        E_FREE:    if (eng_load[i]) eng_st_d[i] = E_LOADED;
        E_LOADED:  if (eng_ready[i]) eng_st_d[i] = eng_done[i] ? E_HOLD : E_RUNNING;
        E_RUNNING: if (eng_done[i]) eng_st_d[i] = E_HOLD;
        E_HOLD:    if (collect && (res_sel_q == SEL_W'(i))) eng_st_d[i] = E_FREE;
        default:   eng_st_d[i] = E_FREE;
      endcase
      hold_d[i] = (eng_st_d[i] == E_HOLD);
    end

    // A done pulse from an engine with no job outstanding is flagged, not acted on.
    proto_err_d = proto_err_q | (|(eng_done & (free_mask | hold_mask)));

    dp_d = dp_q;
    cp_d = cp_q;
    if (clear) begin
      dp_d = '0;
      cp_d = '0;
    end else begin
      if (job_pop) dp_d = rr_next(disp_sel);
      if (collect) cp_d = rr_next(res_sel_q);
    end

    // The presented engine is frozen while the sink stalls, so an engine that
    // enters HOLD closer to cp cannot steal the port mid-handshake.
    res_valid_d = |hold_d;
    if (res_valid_q && !res_ready) res_sel_d = res_sel_q;
    else                           res_sel_d = rr_pick(hold_d, cp_d);

    cycles_d       = cycles_q;
    jobs_issued_d  = jobs_issued_q;
    jobs_retired_d = jobs_retired_q;
    if (clear) begin
      cycles_d       = '0;
      jobs_issued_d  = '0;
      jobs_retired_d = '0;
    end else begin
      if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (cycles_q != 32'hFFFF_FFFF))
        cycles_d = cycles_q + 32'd1;
      if (job_pop) jobs_issued_d = jobs_issued_q + 1'b1;
      if (collect) jobs_retired_d = jobs_retired_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NUM_ENG; i++) eng_st_q[i] <= E_FREE;
      dp_q           <= '0;
      cp_q           <= '0;
      res_valid_q    <= 1'b0;
      res_sel_q      <= '0;
      proto_err_q    <= 1'b0;
      cycles_q       <= '0;
      jobs_issued_q  <= '0;
      jobs_retired_q <= '0;
    end else begin
      state_q        <= state_d;
      for (int i = 0; i < NUM_ENG; i++) eng_st_q[i] <= eng_st_d[i];
      dp_q           <= dp_d;
      cp_q           <= cp_d;
      res_valid_q    <= res_valid_d;
      res_sel_q      <= res_sel_d;
      proto_err_q    <= proto_err_d;
      cycles_q       <= cycles_d;
      jobs_issued_q  <= jobs_issued_d;
      jobs_retired_q <= jobs_retired_d;
    end
  end

  assign eng_start    = loaded_mask;
  assign res_valid    = res_valid_q;
  assign res_sel      = res_sel_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign proto_err    = proto_err_q;
  assign cycles       = cycles_q;
  assign jobs_issued  = jobs_issued_q;
  assign jobs_retired = jobs_retired_q;

endmodule

// File: tb/tb_bs_job_dispatcher.sv
// Directed testbench for bs_job_dispatcher (NUM_ENG=4, CNT_W=16).
// A per-cycle task drives the job source and a latency-programmable engine
// model on the falling edge and records dispatch / collection order.
module tb_bs_job_dispatcher;

  localparam int NE = 4;

  logic        clock = 1'b0;
  logic        reset_n, start, job_avail, out_of_data, res_ready;
  logic [3:0]  eng_ready, eng_done, eng_idle;
  logic        job_pop, res_valid, busy, done, proto_err;
  logic [3:0]  eng_load, eng_start;
  logic [1:0]  res_sel;
  logic [31:0] cycles;
  logic [15:0] jobs_issued, jobs_retired;

  int n_checks = 0;
  int n_fail   = 0;

  bit model_en, src_en;
  int lat [NE];
  bit running [NE];
  int cnt [NE];
  int jobs_left;
  int load_log[$];
  int coll_log[$];

  bs_job_dispatcher #(.NUM_ENG(NE), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .job_avail(job_avail), .out_of_data(out_of_data),
    .job_pop(job_pop), .eng_load(eng_load), .eng_start(eng_start),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_idle(eng_idle),
    .res_valid(res_valid), .res_sel(res_sel), .res_ready(res_ready),
    .busy(busy), .done(done), .proto_err(proto_err), .cycles(cycles),
    .jobs_issued(jobs_issued), .jobs_retired(jobs_retired)
  );

  always #5 clock = ~clock;

  // Engine numbers packed one nibble each, offset by one so order and length show.
  function automatic logic [63:0] pack(input int q[$]);
    logic [63:0] v;
    v = '0;
    foreach (q[i]) v = {v[59:0], 4'(q[i] + 1)};
    return v;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    if (model_en) begin
      for (int i = 0; i < NE; i++) begin
        eng_ready[i] = 1'b0;
        eng_done[i]  = 1'b0;
        if (running[i]) begin
          if (cnt[i] <= 1) begin eng_done[i] = 1'b1; running[i] = 1'b0; end
          else cnt[i]--;
        end else if (eng_start[i]) begin
          eng_ready[i] = 1'b1;
          if (lat[i] <= 1) eng_done[i] = 1'b1;
          else begin running[i] = 1'b1; cnt[i] = lat[i] - 1; end
        end
        eng_idle[i] = ~running[i];
      end
    end
    if (src_en) begin
      job_avail   = (jobs_left > 0);
      out_of_data = (jobs_left == 0);
    end
    #1;
    if (job_pop === 1'b1) begin
      jobs_left--;
      for (int i = 0; i < NE; i++) if (eng_load[i]) load_log.push_back(i);
    end
    if (res_valid === 1'b1 && res_ready === 1'b1) coll_log.push_back(int'(res_sel));
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({job_pop, eng_load, eng_start, res_valid, res_sel, busy, done, proto_err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0",
               {job_pop, eng_load, eng_start, res_valid, res_sel, busy, done, proto_err});
    end
    n_checks++;
    if ({cycles, jobs_issued, jobs_retired} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h required 0", {cycles, jobs_issued, jobs_retired});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/done got %b required 00", {busy, done});
    end
  endtask

  task automatic test_round_robin();
    lat = '{10, 10, 10, 10};
    load_log.delete(); coll_log.delete();
    model_en = 1; src_en = 1; jobs_left = 8; res_ready = 1'b1;
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_start_busy: got %b required 1", busy); end
    run_to_done(300);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rr_done: got %b required 1", done); end
    n_checks++;
    if (pack(load_log) !== 64'h12341234) begin
      n_fail++; $display("FAIL rr_load_order: got %h required 12341234", pack(load_log));
    end
    n_checks++;
    if (pack(coll_log) !== 64'h12341234) begin
      n_fail++; $display("FAIL rr_collect_order: got %h required 12341234", pack(coll_log));
    end
    n_checks++;
    if ({jobs_issued, jobs_retired} !== {16'd8, 16'd8}) begin
      n_fail++; $display("FAIL rr_job_counts: got %0d/%0d required 8/8", jobs_issued, jobs_retired);
    end
    n_checks++;
    if ({proto_err, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rr_err_busy: got %b required 00", {proto_err, busy});
    end
  endtask

  task automatic test_uneven_latency();
    lat = '{20, 5, 5, 5};
    load_log.delete(); coll_log.delete();
    model_en = 1; src_en = 1; jobs_left = 6; res_ready = 1'b1;
    do_start();
    run_to_done(300);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL uneven_done: got %b required 1", done); end
    n_checks++;
    if (pack(load_log) !== 64'h123423) begin
      n_fail++; $display("FAIL uneven_load_order: got %h required 123423", pack(load_log));
    end
    n_checks++;
    if (pack(coll_log) !== 64'h234231) begin
      n_fail++; $display("FAIL uneven_collect_order: got %h required 234231", pack(coll_log));
    end
    n_checks++;
    if ({jobs_issued, jobs_retired} !== {16'd6, 16'd6}) begin
      n_fail++; $display("FAIL uneven_job_counts: got %0d/%0d required 6/6", jobs_issued, jobs_retired);
    end
  endtask

  task automatic test_backpressure();
    lat = '{8, 5, 5, 40};
    load_log.delete(); coll_log.delete();
    model_en = 1; src_en = 1; jobs_left = 4; res_ready = 1'b0;
    do_start();
    for (int k = 0; k < 50 && res_valid !== 1'b1; k++) tick();
    // Engine 0 enters HOLD mid-stall and must not displace engine 1.
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({res_valid, res_sel} !== 3'b101) begin
        n_fail++;
        $display("FAIL bp_hold_cycle%0d: valid/sel got %b required 101", k, {res_valid, res_sel});
      end
      tick();
    end
    n_checks++;
    if (jobs_retired !== 16'd0) begin
      n_fail++; $display("FAIL bp_no_retire_while_stalled: got %0d required 0", jobs_retired);
    end
    res_ready = 1'b1;
    run_to_done(300);
    n_checks++;
    if (pack(coll_log) !== 64'h2314) begin
      n_fail++; $display("FAIL bp_collect_order: got %h required 2314", pack(coll_log));
    end
    n_checks++;
    if ({done, jobs_retired} !== {1'b1, 16'd4}) begin
      n_fail++; $display("FAIL bp_retired: done/retired got %b/%0d required 1/4", done, jobs_retired);
    end
  endtask

  task automatic test_same_cycle_turnaround();
    model_en = 0; src_en = 0; res_ready = 1'b1;
    eng_ready = '0; eng_done = '0; eng_idle = '1;
    out_of_data = 1'b0; job_avail = 1'b1;
    do_start();
    repeat (4) tick();
    job_avail = 1'b0;
    n_checks++;
    if (eng_start !== 4'hF) begin n_fail++; $display("FAIL tat_all_loaded: got %b required 1111", eng_start); end
    eng_ready = 4'b0001; eng_done = 4'b0001;
    tick();
    eng_ready = '0; eng_done = '0;
    n_checks++;
    if ({res_valid, res_sel} !== 3'b100) begin
      n_fail++; $display("FAIL tat_first_result: got %b required 100", {res_valid, res_sel});
    end
    tick();
    // Engine 0 is the only FREE engine: load at t.
    job_avail = 1'b1;
    #1;
    n_checks++;
    if ({job_pop, eng_load} !== 5'b1_0001) begin
      n_fail++; $display("FAIL tat_load_t: got %b required 10001", {job_pop, eng_load});
    end
    tick();
    job_avail = 1'b0;
    n_checks++;
    if ({eng_start, res_valid} !== 5'b1111_0) begin
      n_fail++; $display("FAIL tat_start_t1: got %b required 11110", {eng_start, res_valid});
    end
    eng_ready = 4'b0001; eng_done = 4'b0001;
    tick();
    eng_ready = '0; eng_done = '0;
    n_checks++;
    if ({res_valid, res_sel} !== 3'b100) begin
      n_fail++; $display("FAIL tat_result_t2: got %b required 100", {res_valid, res_sel});
    end
    tick();
    job_avail = 1'b1;
    #1;
    n_checks++;
    if ({job_pop, eng_load} !== 5'b1_0001) begin
      n_fail++; $display("FAIL tat_reload_t3: got %b required 10001", {job_pop, eng_load});
    end
    tick();
    job_avail = 1'b0;
    eng_ready = '1; eng_done = '1;
    tick();
    eng_ready = '0; eng_done = '0; out_of_data = 1'b1;
    run_to_done(20);
    n_checks++;
    if ({done, proto_err, jobs_issued, jobs_retired} !== {1'b1, 1'b0, 16'd6, 16'd6}) begin
      n_fail++;
      $display("FAIL tat_finish: done/err/issued/retired got %b/%b/%0d/%0d required 1/0/6/6",
               done, proto_err, jobs_issued, jobs_retired);
    end
  endtask

  task automatic test_empty_run();
    model_en = 0; src_en = 0; job_avail = 1'b0; out_of_data = 1'b1; eng_idle = '1;
    do_start();
    n_checks++;
    if ({busy, cycles, jobs_issued} !== {1'b1, 32'd0, 16'd0}) begin
      n_fail++; $display("FAIL empty_cleared: busy/cycles/issued got %b/%0d/%0d required 1/0/0",
                         busy, cycles, jobs_issued);
    end
    tick();
    n_checks++;
    if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL empty_drain: got %b required 10", {busy, done}); end
    tick();
    n_checks++;
    if ({done, busy, cycles} !== {1'b1, 1'b0, 32'd2}) begin
      n_fail++; $display("FAIL empty_done: done/busy/cycles got %b/%b/%0d required 1/0/2", done, busy, cycles);
    end
    tick();
    n_checks++;
    if (cycles !== 32'd2) begin n_fail++; $display("FAIL empty_cycles_frozen: got %0d required 2", cycles); end
  endtask

  task automatic test_reset_midrun();
    lat = '{100, 100, 100, 100};
    model_en = 1; src_en = 1; jobs_left = 3; res_ready = 1'b1;
    do_start();
    repeat (6) tick();
    n_checks++;
    if ({busy, jobs_issued} !== {1'b1, 16'd3}) begin
      n_fail++; $display("FAIL mid_inflight: busy/issued got %b/%0d required 1/3", busy, jobs_issued);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({job_pop, eng_load, eng_start, res_valid, res_sel, busy, done, proto_err, cycles, jobs_issued}
        !== 63'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: ctrl %b cycles %0d issued %0d required all 0",
               {job_pop, eng_load, eng_start, res_valid, res_sel, busy, done, proto_err},
               cycles, jobs_issued);
    end
    model_en = 0; src_en = 0;
    for (int i = 0; i < NE; i++) begin running[i] = 0; cnt[i] = 0; end
    eng_ready = '0; eng_done = '0; eng_idle = '1; job_avail = 1'b0; out_of_data = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
    n_checks++;
    if ({proto_err, busy} !== 2'b10) begin
      n_fail++; $display("FAIL mid_stray_done: err/busy got %b required 10", {proto_err, busy});
    end
    lat = '{3, 3, 3, 3};
    load_log.delete(); coll_log.delete();
    model_en = 1; src_en = 1; jobs_left = 4;
    do_start();
    run_to_done(200);
    n_checks++;
    if ({done, jobs_issued, jobs_retired} !== {1'b1, 16'd4, 16'd4}) begin
      n_fail++; $display("FAIL mid_rerun: done/issued/retired got %b/%0d/%0d required 1/4/4",
                         done, jobs_issued, jobs_retired);
    end
    n_checks++;
    if (pack(load_log) !== 64'h1234) begin
      n_fail++; $display("FAIL mid_rerun_order: got %h required 1234", pack(load_log));
    end
    n_checks++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL mid_err_sticky: got %b required 1", proto_err); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; job_avail = 1'b0; out_of_data = 1'b0; res_ready = 1'b0;
    eng_ready = '0; eng_done = '0; eng_idle = '1;
    model_en = 0; src_en = 0; jobs_left = 0;
    for (int i = 0; i < NE; i++) begin running[i] = 0; cnt[i] = 0; lat[i] = 1; end
    test_reset();
    test_round_robin();
    test_uneven_latency();
    test_backpressure();
    test_same_cycle_turnaround();
    test_empty_run();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bs_job_dispatcher.md
# bs_job_dispatcher

Schedules option-pricing jobs from the data controller onto a pool of NUM_ENG Black-Scholes engines and collects their results back onto a single result port. It runs round-robin dispatch and round-robin result collection, keeps per-engine occupancy state, and reports run completion, cycle count and job counts. It sits between the data controller (job source and result sink) and the Black-Scholes engine array.

## Interface
- NUM_ENG, 4: number of Black-Scholes engines (2..16).
- CNT_W, 16: width of the job counters.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- job_avail  in  1  data controller has a job staged.
- out_of_data  in  1  level: no further jobs will be staged this run.
- job_pop  out  1  staged job consumed this cycle.
- eng_load  out  NUM_ENG  one-hot, with job_pop: engine i latches the staged job.
- eng_start  out  NUM_ENG  level start per engine.
- eng_ready  in  NUM_ENG  engine accepted start.
- eng_done  in  NUM_ENG  one-cycle pulse: result valid at engine output.
- eng_idle  in  NUM_ENG  engine idle.
- res_valid  out  1  a result is presented.
- res_sel  out  clog2(NUM_ENG)  engine whose result is presented.
- res_ready  in  1  data controller takes the result.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- proto_err  out  1  sticky: eng_done seen from an engine not in LOADED/RUNNING.
- cycles  out  32  run length in clocks.
- jobs_issued, jobs_retired  out  CNT_W  per-run job counts.

## Operation
- Top FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. On entry, clear cycles, the job counters and both round-robin pointers.
  - RUN -> DRAIN when out_of_data=1 and job_avail=0.
  - DRAIN -> DONE when every engine is FREE and eng_idle is all ones.
  - DONE -> RUN on start, with the same clears as IDLE -> RUN.
  - start while in RUN or DRAIN is ignored.
- Each engine has its own state machine: FREE -> LOADED -> RUNNING -> HOLD -> FREE.
- Dispatch happens in RUN only, at most one job per cycle.
  - Condition: job_avail=1 and at least one engine is FREE.
  - The block selects the first FREE engine at or after dispatch pointer dp, wrapping modulo NUM_ENG.
  - In that cycle: job_pop=1 and eng_load[i]=1. Next cycle: engine i is LOADED and dp=i+1 mod NUM_ENG.
- LOADED: eng_start[i]=1. When eng_ready[i]=1, the engine goes to RUNNING. If eng_ready[i] and eng_done[i] are high together, it goes straight to HOLD.
- RUNNING: eng_done[i] moves the engine to HOLD.
- Result collection (HOLD engines):
  - res_valid=1 whenever any engine is in HOLD. res_sel is the first HOLD engine at or after collection pointer cp.
  - res_sel stays stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready: that engine goes to FREE, cp=res_sel+1 mod NUM_ENG, and jobs_retired increments.
- An engine freed in cycle t is dispatchable no earlier than cycle t+1.
- Dispatch and collection may occur in the same cycle on different engines.
- Counters:
  - cycles increments every clock in RUN and DRAIN and saturates at 0xFFFFFFFF.
  - jobs_issued increments on job_pop. Job counters wrap modulo 2^CNT_W.
- proto_err: set by eng_done[i] while engine i is FREE or HOLD. The pulse is otherwise ignored. Cleared only by reset.

## Timing
- Reset values: FSM=IDLE, all engines FREE, dp=cp=0, cycles=0, job counters=0.
- All outputs read 0 in reset, including res_sel.
- job_pop and eng_load are combinational from registered state and job_avail, so the data controller must hold job_avail stable within a cycle.
- All other outputs (eng_start, res_valid, res_sel, busy, done, counters) are registered.
- Latencies:
  - job_pop in cycle t -> eng_start[i] high from t+1.
  - eng_done in cycle t -> res_valid high from t+1.
- Minimum engine turnaround is 4 cycles:
  - load at t
  - start at t+1, with eng_ready and eng_done high in the same cycle
  - res_valid at t+2, collected at t+2
  - engine FREE at t+3, dispatch again at t+3
- start -> busy=1 at the next edge.
- DRAIN exit condition met in cycle t -> done=1 at t+1. cycles freezes at its final value.
- Reset asserted mid-run clears everything asynchronously. Jobs in flight are discarded; the data controller is reset alongside.

## Test plan
- NUM_ENG=4, 8 jobs, engines complete in 10 cycles, res_ready tied high -> eng_load order 0,1,2,3,0,1,2,3; jobs_issued=jobs_retired=8; done=1; proto_err=0.
- Engine latencies {20,5,5,5}, 4 jobs -> results collected in order 1,2,3,0; no dispatch to engine 0 until it is collected.
- res_ready held low 6 cycles while engines 1 and 2 are in HOLD -> res_sel=1 stable for all 6 cycles, then 1 is collected, then 2; no result lost.
- eng_ready and eng_done on the same cycle for engine 0 -> engine goes LOADED->HOLD; res_valid=1 next cycle; minimum turnaround is 4 cycles.
- out_of_data=1 with job_avail=0 immediately after start -> RUN->DRAIN->DONE, jobs_issued=0, cycles=2.
- reset_n low mid-run with 3 engines busy -> all outputs 0 immediately; stray eng_done after reset sets proto_err=1; a second start runs normally.
